// File: rtl/mcu_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: FSM states, opcodes, funct codes
// and ALU operation encodings.
package mcu_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mcu_alu_decoder.sv
// Combinational R-type funct decoder: ALU operation plus a flag for recognised funct codes.
module mcu_alu_decoder
    import mcu_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 3
) (
    input  logic [5:0]            funct_i,
    output logic [ALU_CTRL_W-1:0] alu_control_o,
    output logic                  funct_valid_o
);

    always_comb begin
        alu_control_o = ALU_CTRL_W'(ALU_ADD);
        funct_valid_o = 1'b1;
        case (funct_i)
            FN_ADD:  alu_control_o = ALU_CTRL_W'(ALU_ADD);
            FN_SUB:  alu_control_o = ALU_CTRL_W'(ALU_SUB);
            FN_AND:  alu_control_o = ALU_CTRL_W'(ALU_AND);
            FN_OR:   alu_control_o = ALU_CTRL_W'(ALU_OR);
            FN_SLT:  alu_control_o = ALU_CTRL_W'(ALU_SLT);
            default: funct_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM with memory-wait timeout and halt state.
// Define MCU_ILLEGAL_TRAP_EN to halt on unknown opcode/funct and expose illegal_instr.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W  = 3,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  iord,
    output logic                  ir_write,
    output logic                  pc_en,
    output logic [1:0]            pc_src,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  reg_write,
    output logic [1:0]            reg_dst,
    output logic                  memto_reg,
    output logic                  link,
    output logic                  halted,
    output logic                  timeout_err
`ifdef MCU_ILLEGAL_TRAP_EN
    ,
    output logic                  illegal_instr
`endif
);

    localparam int unsigned CntW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MEM_TIMEOUT);

    state_e                  state_q, state_d;
    logic [CntW-1:0]         wait_cnt_q, wait_cnt_d;
    logic                    timeout_err_q, timeout_err_d;
    logic [ALU_CTRL_W-1:0]   dec_alu_control;
    logic                    funct_valid;
    logic                    illegal_set;

    mcu_alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_decoder (
        .funct_i       (funct),
        .alu_control_o (dec_alu_control),
        .funct_valid_o (funct_valid)
    );

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        illegal_set   = 1'b0;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_en         = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_control   = '0;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        memto_reg     = 1'b0;
        link          = 1'b0;
        halted        = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_req     = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = ALU_CTRL_W'(ALU_ADD);
                ir_write    = mem_ready;
                pc_en       = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = ALU_CTRL_W'(ALU_ADD);
                case (opcode)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_RTYPE:         state_d = S_EXEC;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI: state_d = S_IEXEC;
                    OP_J, OP_JAL:     state_d = S_JUMP;
                    default: begin
`ifdef MCU_ILLEGAL_TRAP_EN
                        state_d     = S_HALT;
                        illegal_set = 1'b1;
`else
                        state_d     = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_CTRL_W'(ALU_ADD);
                state_d     = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                memto_reg = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = dec_alu_control;
                state_d     = S_ALUWB;
`ifdef MCU_ILLEGAL_TRAP_EN
                if (!funct_valid) begin
                    state_d     = S_HALT;
                    illegal_set = 1'b1;
                end
`endif
            end
            S_ALUWB: begin
                // funct is still held in IR, so an unknown funct writes nothing back
                reg_write = funct_valid;
                reg_dst   = 2'b01;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_CTRL_W'(ALU_SUB);
                pc_src      = 2'b01;
                pc_en       = (opcode == OP_BEQ) ? zero : ~zero;
                state_d     = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = (opcode == OP_ANDI) ? ALU_CTRL_W'(ALU_AND) : ALU_CTRL_W'(ALU_ADD);
                state_d     = S_IWB;
            end
            S_IWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_en   = 1'b1;
                pc_src  = 2'b10;
                state_d = S_FETCH;
                if (opcode == OP_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b10;
                    link      = 1'b1;
                end
            end
            S_HALT:  halted  = 1'b1;
            default: state_d = S_RESET;
        endcase

        // The limit is hit on the MEM_TIMEOUT-th consecutive wait; a ready in that cycle wins.
        if (mem_req && !mem_ready) begin
            if (MEM_TIMEOUT != 0 && wait_cnt_q >= CntLast) begin
                state_d       = S_HALT;
                timeout_err_d = 1'b1;
            end
            wait_cnt_d = (wait_cnt_q >= CntMax) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = '0;
        end
        if (state_d != state_q) wait_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RESET;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;

`ifdef MCU_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (illegal_set) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_instr = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_set;
`endif

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor of the single-cycle MIPS control unit: one instruction takes 3-5 states, and memory accesses stall on a ready handshake.
- Drives the shared-memory multi-cycle datapath (PC, IR, register file, ALU, single memory port).
- Covers lw, sw, R-type (add/sub/and/or/slt), beq, bne, addi, andi, j, jal.
- Adds a memory-wait timeout and a halt state.

Parameters:
- ALU_CTRL_W, 3, alu_control width; encodings: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- MEM_TIMEOUT, 16, maximum consecutive wait cycles for mem_ready before halting; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], valid from S_DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  write qualifier for mem_req.
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR.
- pc_en  out  1  PC load enable.
- pc_src  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B: 00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- alu_control  out  ALU_CTRL_W  ALU operation.
- reg_write  out  1  register file write.
- reg_dst  out  2  destination: 00 rt, 01 rd, 10 r31.
- memto_reg  out  1  write-back data: 1 = MDR, 0 = ALUOut.
- link  out  1  write PC+4 (jal).
- halted  out  1  in S_HALT.
- timeout_err  out  1  sticky; set on memory timeout.

Behaviour:
- 4-bit state register; the asynchronous reset sets state = S_RESET, wait_cnt = 0, timeout_err = 0.
- In S_RESET, all outputs are 0 (reset value of every output). Next state is S_FETCH.
- Outputs are Moore, decoded from state, except pc_en, ir_write and reg_write, which are gated as listed below. Every signal not listed for a state is 0.
- S_FETCH: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_control = add, pc_src = 00.
  - ir_write = pc_en = mem_ready. No PC/IR update while waiting.
  - mem_ready -> S_DECODE; otherwise stay.
- S_DECODE: alu_src_a = 0, alu_src_b = 11, alu_control = add (branch target).
  - Opcode dispatch: lw/sw -> S_MEMADR; R-type (000000) -> S_EXEC; beq (000100)/bne (000101) -> S_BRANCH; addi (001000)/andi (001100) -> S_IEXEC; j (000010)/jal (000011) -> S_JUMP.
  - Any other opcode -> S_FETCH (treated as NOP).
- S_MEMADR: alu_src_a = 1, alu_src_b = 10, add. lw -> S_MEMRD; sw -> S_MEMWR.
- S_MEMRD: mem_req = 1, iord = 1. Stall until mem_ready, then -> S_MEMWB.
- S_MEMWB: reg_write = 1, reg_dst = 00, memto_reg = 1 -> S_FETCH.
- S_MEMWR: mem_req = 1, mem_write = 1, iord = 1. Stall until mem_ready, then -> S_FETCH.
- S_EXEC: alu_src_a = 1, alu_src_b = 00. alu_control from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown funct: alu_control = add, and S_ALUWB suppresses reg_write.
  - -> S_ALUWB.
- S_ALUWB: reg_write = 1, reg_dst = 01 -> S_FETCH.
- S_BRANCH: alu_src_a = 1, alu_src_b = 00, sub, pc_src = 01.
  - pc_en = beq ? zero : ~zero. -> S_FETCH.
- S_IEXEC: alu_src_a = 1, alu_src_b = 10; alu_control = add for addi, and for andi. -> S_IWB.
- S_IWB: reg_write = 1, reg_dst = 00 -> S_FETCH.
- S_JUMP: pc_en = 1, pc_src = 10.
  - jal additionally: reg_write = 1, reg_dst = 10, link = 1.
  - -> S_FETCH.
- Opcode and funct are sampled from the IR each cycle; they are stable after S_FETCH.
- Timeout: wait_cnt counts consecutive cycles with mem_req = 1 and mem_ready = 0, and clears on mem_ready or on any state change.
  - When MEM_TIMEOUT != 0 and wait_cnt reaches MEM_TIMEOUT: -> S_HALT, set timeout_err.
  - mem_ready arriving in the same cycle as the count reaches the limit wins: the access completes and no error is raised.
  - wait_cnt saturates; its width is clog2(MEM_TIMEOUT+1).
- S_HALT: halted = 1, all strobes 0. Absorbing; only rst_n leaves it.
- Reset asserted mid-instruction immediately returns to S_RESET with outputs 0. The partial instruction is discarded.

Optional Feature:
- MCU_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in S_DECODE, or an unknown funct in S_EXEC, goes to S_HALT with halted = 1 and an extra output illegal_instr = 1 (sticky until reset).
- Undefined: both cases are NOP as described above, and the illegal_instr port does not exist.

Decomposition:
- Package mcu_pkg holds:
  - state localparams S_RESET..S_HALT;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_J, OP_JAL;
  - funct constants;
  - ALU_ADD/SUB/AND/OR/SLT codes.
- One sub-module, mcu_alu_decoder: combinational funct -> alu_control plus a funct_valid output.

Test Plan:
- Reset held 3 cycles, then released with mem_ready = 1: outputs all 0 during reset, S_FETCH on the first edge, ir_write = pc_en = 1 on the second cycle.
- lw (100011) with mem_ready delayed 3 cycles in S_MEMRD: mem_req held 3 cycles, iord = 1; then reg_write = 1, memto_reg = 1 in S_MEMWB. 5 states total plus waits.
- beq with zero = 1, then bne with zero = 1: pc_en = 1 in S_BRANCH for beq, pc_en = 0 for bne; both return to S_FETCH.
- R-type funct 101010: alu_control = 111 in S_EXEC, then reg_write = 1, reg_dst = 01.
- jal (000011): in S_JUMP pc_en = 1, pc_src = 10, reg_write = 1, reg_dst = 10, link = 1.
- MEM_TIMEOUT = 4, mem_ready held 0 in S_FETCH: after 4 wait cycles, halted = 1 and timeout_err = 1. The state stays halted until rst_n pulses low.
